// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM serial scheduler.
package tdm_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_DATA = 2'b10,
    ST_GAP  = 2'b11
  } tdm_state_e;

  // Requester index reached by walking `off` slots upward from `base`, modulo n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping upward.
module rr_arbiter
  import tdm_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index,
  output logic          any
);
  int w_k;

  always_comb begin
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    w_k   = 0;
    for (int i = 0; i < N; i++) begin
      w_k = rr_wrap(int'(ptr), i, N);
      if (!any && req[w_k]) begin
        any      = 1'b1;
        gnt[w_k] = 1'b1;
        index    = IW'(w_k);
      end
    end
  end
endmodule

// File: rtl/tdm_scheduler.sv
// Time-division scheduler: round-robin grant, then SYNC + DW serial bits (MSB first) + GAP per frame.
module tdm_scheduler
  import tdm_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     q,
  output logic                     sync,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  tdm_state_e      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_gnt_id;
  logic [DW-1:0]   r_sh;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_arb;
  logic [IW-1:0]   w_ptr_nxt;
  logic [DW-1:0]   w_win_data;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .gnt   (w_gnt),
    .index (w_idx),
    .any   (w_any)
  );

  assign w_arb      = (r_state == ST_IDLE) || (r_state == ST_GAP);
  assign w_ptr_nxt  = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_win_data = req_data[int'(w_idx)*DW +: DW];

  // Reset is folded in so the strobe drops the instant reset rises, not at the next edge.
  assign req_ready = (w_arb && !reset) ? w_gnt : '0;

  assign q      = (r_state == ST_DATA) && r_sh[DW-1];
  assign sync   = (r_state == ST_SYNC);
  assign busy   = (r_state == ST_SYNC) || (r_state == ST_DATA);
  assign gnt_id = r_gnt_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_any) begin
            r_sh     <= w_win_data;
            r_gnt_id <= w_idx;
            r_ptr    <= w_ptr_nxt;
            r_state  <= ST_SYNC;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_SYNC: begin
          r_cnt   <= CW'(DW - 1);
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_sh <= {r_sh[DW-2:0], 1'b0};
          if (r_cnt == '0) r_state <= ST_GAP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdm_scheduler.sv
// Bench for tdm_scheduler: requester queues drive the inputs, a frame monitor checks against expected frames.
module tb_tdm_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        q, sync, busy;
  logic [1:0]  gnt_id;

  tdm_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .sync      (sync),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] id; logic [7:0] d; } frm_t;
  typedef struct { logic [3:0] valid; logic [31:0] data; int n; logic [7:0] ord; } vec_t;

  frm_t       exp_q[$];
  int         n_cmp = 0, n_err = 0;
  logic [7:0] pdata [4][16];
  int         phead [4] = '{default: 0};
  int         ptail [4] = '{default: 0};
  int         ready_cnt [4] = '{default: 0};
  logic [3:0] ready_seen = '0;
  int         cyc = 0, mon_cnt = -1, last_sync = -1;
  bit         chk_sp = 1'b0;
  logic [1:0] mon_id;
  logic [7:0] mon_bits;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] d);
    pdata[i][ptail[i] % 16] = d;
    ptail[i]++;
  endtask

  task automatic expect_frm(input logic [1:0] id, input logic [7:0] d);
    frm_t f;
    f.id = id;
    f.d  = d;
    exp_q.push_back(f);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || mon_cnt != -1) && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_left", exp_q.size() + ((mon_cnt != -1) ? 1 : 0), 0);
    exp_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester model: hold valid/data until accepted, then present the next queued payload.
  initial begin
    logic [3:0] acc;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) phead[i]++;
        req_valid[i] = (phead[i] != ptail[i]);
        req_data[i*8 +: 8] = req_valid[i] ? pdata[i][phead[i] % 16] : 8'h00;
      end
    end
  end

  // Frame monitor: SYNC, DW bits, GAP; compares each finished frame against the scoreboard.
  initial forever begin
    @(negedge clk);
    chk("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
    ready_seen = ready_seen | req_ready;
    for (int i = 0; i < 4; i++) ready_cnt[i] += int'(req_ready[i]);
    if (reset) begin
      mon_cnt = -1;
    end else if (mon_cnt == -2) begin
      chk("gap_sync_q_busy", {sync, q, busy}, 3'b000);
      mon_cnt = -1;
    end else if (mon_cnt >= 0) begin
      chk("data_sync_busy", {sync, busy}, 2'b01);
      mon_bits = {mon_bits[6:0], q};
      mon_cnt++;
      if (mon_cnt == DW) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {mon_id, mon_bits}, 0);
        end else begin
          frm_t e;
          e = exp_q.pop_front();
          chk("frame_id", mon_id, e.id);
          chk("frame_data", mon_bits, e.d);
        end
        mon_cnt = -2;
      end
    end else if (sync) begin
      chk("sync_q_busy", {q, busy}, 2'b01);
      if (chk_sp && last_sync >= 0) chk("sync_spacing", cyc - last_sync, DW + 2);
      last_sync = cyc;
      mon_id    = gnt_id;
      mon_bits  = '0;
      mon_cnt   = 0;
    end else begin
      chk("idle_q_busy", {q, busy}, 2'b00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [5];
    logic [7:0] pat;
    logic [3:0] one;
    logic [1:0] id;
    int         t;

    // Hand-derived order; ptr enters the table at 1 and carries between rows.
    tbl[0] = '{4'b1001, 32'h33000011, 2, 8'h03};
    tbl[1] = '{4'b0110, 32'h003CC300, 2, 8'h09};
    tbl[2] = '{4'b1111, 32'hDEADBEEF, 4, 8'h93};
    tbl[3] = '{4'b0001, 32'h00000080, 1, 8'h00};
    tbl[4] = '{4'b0100, 32'h00010000, 1, 8'h02};
    one = 4'b0001;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_sync", sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gnt", gnt_id, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); #1;

    // Single request, exact bit sequence
    pat = 8'hA5;
    push_req(2, pat); expect_frm(2, pat);
    @(posedge clk); @(negedge clk);
    chk("a5_ready", req_ready, 4'b0100);
    @(negedge clk);
    chk("a5_sync", sync, 1);
    chk("a5_gnt", gnt_id, 2);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("a5_bit", q, pat[7-b]);
    end
    wait_drain(100);

    // Long idle, then a lone request
    repeat (20) @(negedge clk);
    chk("idle_state", {q, sync, busy}, 3'b000);
    #1;
    push_req(0, 8'h42); expect_frm(0, 8'h42);
    @(posedge clk); @(negedge clk);
    chk("r0_ready", req_ready, 4'b0001);
    @(negedge clk);
    chk("r0_sync", sync, 1);
    wait_drain(100);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++)
        if (tbl[v].valid[i]) push_req(i, tbl[v].data[i*8 +: 8]);
      for (int k = 0; k < tbl[v].n; k++) begin
        id = tbl[v].ord[2*k +: 2];
        expect_frm(id, tbl[v].data[int'(id)*8 +: 8]);
      end
      id = tbl[v].ord[1:0];
      @(posedge clk); @(negedge clk);
      chk("tbl_first_ready", req_ready, one << id);
      wait_drain(300);
    end

    // Reset during DATA bit 4 of 0x5A (that bit is a 1)
    push_req(1, 8'h5A); expect_frm(1, 8'h5A);
    t = 0;
    do begin @(negedge clk); t++; end while (!sync && t < 50);
    chk("rst_mid_sync_seen", sync, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    chk("pre_rst_q", q, 1);
    reset = 1'b1; #1;
    chk("mid_rst_outs", {q, sync, busy}, 3'b000);
    chk("mid_rst_ready", req_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_gnt", gnt_id, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); #1;
    push_req(3, 8'h96); expect_frm(3, 8'h96);
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", req_ready, 4'b1000);
    wait_drain(100);

    // Fairness skip with only requesters 1 and 3
    ready_seen = '0;
    push_req(1, 8'h01); push_req(1, 8'h02);
    push_req(3, 8'h03); push_req(3, 8'h04);
    expect_frm(1, 8'h01); expect_frm(3, 8'h03);
    expect_frm(1, 8'h02); expect_frm(3, 8'h04);
    wait_drain(300);
    chk("fair_ready_02", ready_seen & 4'b0101, 4'b0000);
    chk("fair_ready_13", ready_seen & 4'b1010, 4'b1010);

    // All four continuously valid
    for (int i = 0; i < 4; i++) ready_cnt[i] = 0;
    last_sync = -1;
    chk_sp    = 1'b1;
    push_req(0, 8'h10); push_req(0, 8'h50);
    push_req(1, 8'h20); push_req(2, 8'h30); push_req(3, 8'h40);
    expect_frm(0, 8'h10); expect_frm(1, 8'h20); expect_frm(2, 8'h30);
    expect_frm(3, 8'h40); expect_frm(0, 8'h50);
    wait_drain(300);
    chk("rr_cnt0", ready_cnt[0], 2);
    chk("rr_cnt1", ready_cnt[1], 1);
    chk("rr_cnt2", ready_cnt[2], 1);
    chk("rr_cnt3", ready_cnt[3], 1);

    // 0xFF then 0x00 back to back
    last_sync = -1;
    push_req(1, 8'hFF); push_req(2, 8'h00);
    expect_frm(1, 8'hFF); expect_frm(2, 8'h00);
    wait_drain(200);
    chk_sp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
